escalonador_instrucoes: RTL and testbench
=========================================

Name: escalonador_instrucoes

Overview:
- Time-slice scheduler and address translator in front of the instruction RAM.
- The RAM is partitioned into fixed 200-word regions:
  - region 0: context-switch routine
  - region 1: operating system
  - regions 2..NUM_PROGS+1: user programs
- The block converts the processor's logical PC into a physical RAM address (partition base + PC).
- It counts retired user instructions, forces a context switch when the quantum expires or a program ends, and sequences routine -> OS -> selected program.

Parameters:
- ADDR_WIDTH, 32, width of logical PC and physical address.
- PARTITION_SIZE, 200, words per partition.
- NUM_PROGS, 2, number of user program partitions (max 8).
- QUANTUM, 64, user instructions retired before a forced switch.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc_logico  in  ADDR_WIDTH  logical PC from the fetch stage.
- instr_ret  in  1  one-cycle pulse per retired instruction.
- prog_fim  in  1  pulse: current user program executed its halt.
- rotina_fim  in  1  pulse: context-switch routine finished.
- so_fim  in  1  pulse: OS finished; proximo_proc is valid this cycle.
- proximo_proc  in  3  program index chosen by the OS (0..NUM_PROGS-1).
- endereco  out  ADDR_WIDTH  physical address to the instruction RAM.
- troca_req  out  1  one-cycle pulse: processor must jump to logical 0 (flush).
- modo_kernel  out  1  1 in ROTINA/SO, 0 in USER.
- proc_atual  out  3  index of current/last user program.
- ativos  out  NUM_PROGS  bitmask of unfinished programs.
- concluido  out  1  all programs finished.

Behaviour:
- Reset values:
  - state=SO, proc_atual=0, quantum counter=0, ativos=all ones, troca_req=0, concluido=0.
  - modo_kernel=1, endereco=PARTITION_SIZE+pc_logico.
- endereco is combinational: base(state,proc_atual) + pc_logico.
  - Base values: ROTINA 0; SO PARTITION_SIZE; USER (proc_atual+2)*PARTITION_SIZE.
  - Bases come from a constant table, with no multiplier.
  - The sum is truncated to ADDR_WIDTH.
  - The RAM's one-cycle read latency is unaffected.
- States: USER, ROTINA, SO, FIM.
- USER:
  - Each instr_ret increments the quantum counter.
  - When the count reaches QUANTUM-1 and instr_ret=1: troca_req pulses next cycle, counter clears, state->ROTINA.
  - prog_fim: clear ativos[proc_atual], troca_req pulse, counter clears, state->ROTINA.
  - prog_fim and quantum expiry in the same cycle: a single switch occurs and the bit is cleared.
- ROTINA:
  - instr_ret is ignored; the counter holds 0.
  - rotina_fim -> SO with a troca_req pulse.
  - Transition -> FIM instead if ativos==0.
- SO:
  - On so_fim, if ativos[proximo_proc]=1 and proximo_proc<NUM_PROGS: proc_atual<=proximo_proc, state->USER, troca_req pulse.
  - Otherwise (invalid or finished index): choose the next active index round-robin after proc_atual. Wrap NUM_PROGS-1 -> 0.
  - so_fim with ativos==0 -> FIM.
- FIM:
  - concluido=1, modo_kernel=1, endereco=PARTITION_SIZE+pc_logico.
  - All inputs are ignored until reset.
- troca_req is registered, exactly one cycle wide, and coincides with the first cycle of the new state.
- Pulses on rotina_fim/so_fim/prog_fim arriving in a state that does not consume them are ignored.
- reset_n low at any time returns all state immediately; there is no partial-switch recovery.

Optional Feature:
- SCHED_LIMIT_CHECK_EN
  - Defined: in USER, pc_logico >= PARTITION_SIZE is a fault.
    - endereco is forced to the program's base.
    - The program's ativos bit is cleared.
    - troca_req pulses and state->ROTINA, same as prog_fim.
    - An extra output, falha_limite, is a sticky bit cleared only by reset.
  - Undefined: no check; out-of-range PCs translate unmodified; port falha_limite is absent.

Decomposition:
- Package escalonador_pkg:
  - state encoding (USER, ROTINA, SO, FIM)
  - BASE_ROTINA, BASE_SO, PARTITION_SIZE
  - the base-address function for program index
- One sub-module, seletor_round_robin: given ativos, the current index, and the requested index, returns the next valid index and a none-left flag. It is purely combinational and reused for both the so_fim fallback and FIM detection.

Test Plan:
- Reset, then pc_logico=5 -> endereco=205, modo_kernel=1. so_fim with proximo_proc=1 -> next cycle troca_req=1, proc_atual=1, endereco=605.
- In USER proc 0, apply 64 instr_ret pulses -> troca_req after the 64th, state ROTINA, endereco=pc_logico. 63 pulses -> no switch.
- prog_fim on proc 0 -> ativos=2'b10, ROTINA. rotina_fim -> SO. so_fim proximo_proc=0 -> round-robin selects 1, endereco=600+pc.
- prog_fim for both programs, then rotina_fim -> FIM, concluido=1. Later so_fim/instr_ret are ignored.
- prog_fim and 64th instr_ret in the same cycle -> exactly one troca_req, bit cleared. Assert reset_n mid-ROTINA -> immediate SO, ativos all ones.
- With SCHED_LIMIT_CHECK_EN, in USER proc 1, pc_logico=200 -> endereco=600, falha_limite=1, ativos[1]=0, troca_req pulse.

Source files
------------

// File: rtl/escalonador_instrucoes_pkg.sv
// Shared types and constants for the instruction scheduler/address translator.
// Partition layout: 0 = switch routine, 1 = OS, 2.. = user programs.
package escalonador_pkg;

   typedef enum logic [1:0] {
      USER,
      ROTINA,
      SO,
      FIM
   } estado_t;

   localparam int unsigned PARTITION_SIZE = 200;
   localparam int unsigned MAX_PROGS      = 8;
   localparam int unsigned BASE_ROTINA    = 0;
   localparam int unsigned BASE_SO        = PARTITION_SIZE;

   // Only ever called with constant arguments, so it folds into a table.
   function automatic longint unsigned base_prog(input int unsigned idx,
                                                 input int unsigned part);
      return 64'(idx + 2) * 64'(part);
   endfunction

endpackage

// File: rtl/escalonador_instrucoes_if.sv
// Processor-side bus of the scheduler; falha_limite exists only when
// SCHED_LIMIT_CHECK_EN is defined.
interface escalonador_instrucoes_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_PROGS  = 2
);
   logic [ADDR_WIDTH-1:0] pc_logico;
   logic                  instr_ret;
   logic                  prog_fim;
   logic                  rotina_fim;
   logic                  so_fim;
   logic [2:0]            proximo_proc;
   logic [ADDR_WIDTH-1:0] endereco;
   logic                  troca_req;
   logic                  modo_kernel;
   logic [2:0]            proc_atual;
   logic [NUM_PROGS-1:0]  ativos;
   logic                  concluido;
`ifdef SCHED_LIMIT_CHECK_EN
   logic                  falha_limite;

   modport master (output pc_logico, instr_ret, prog_fim, rotina_fim, so_fim, proximo_proc,
                   input  endereco, troca_req, modo_kernel, proc_atual, ativos, concluido,
                          falha_limite);
   modport slave  (input  pc_logico, instr_ret, prog_fim, rotina_fim, so_fim, proximo_proc,
                   output endereco, troca_req, modo_kernel, proc_atual, ativos, concluido,
                          falha_limite);
`else
   modport master (output pc_logico, instr_ret, prog_fim, rotina_fim, so_fim, proximo_proc,
                   input  endereco, troca_req, modo_kernel, proc_atual, ativos, concluido);
   modport slave  (input  pc_logico, instr_ret, prog_fim, rotina_fim, so_fim, proximo_proc,
                   output endereco, troca_req, modo_kernel, proc_atual, ativos, concluido);
`endif
endinterface

// File: rtl/escalonador_instrucoes_seletor_round_robin.sv
// Combinational program picker: honours the requested index when it is live,
// otherwise takes the first live index after the current one.
module seletor_round_robin
   import escalonador_pkg::*;
#(
   parameter int unsigned NUM_PROGS = 2
) (
   input  logic [NUM_PROGS-1:0] ativos,
   input  logic [2:0]           atual,
   input  logic [2:0]           pedido,
   output logic [2:0]           proximo,
   output logic                 nenhum
);

   logic [MAX_PROGS-1:0] ativos_ext;
   logic [3:0]           cand;

   // Zero-padding makes out-of-range requests read as finished programs.
   assign ativos_ext = MAX_PROGS'(ativos);
   assign nenhum     = ~|ativos;

   always_comb begin
      proximo = atual;
      cand    = '0;
      if (ativos_ext[pedido]) begin
         proximo = pedido;
      end else begin
         // Walk from farthest to nearest so the nearest live index wins.
         for (int unsigned i = NUM_PROGS; i >= 1; i--) begin
            cand = {1'b0, atual} + 4'(i);
            if (cand >= 4'(NUM_PROGS)) cand = cand - 4'(NUM_PROGS);
            if (ativos_ext[cand[2:0]]) proximo = cand[2:0];
         end
      end
   end

endmodule

// File: rtl/escalonador_instrucoes.sv
// Time-slice scheduler and logical->physical PC translator for the instruction RAM.
// Optional macro SCHED_LIMIT_CHECK_EN: faults user PCs outside their partition.
module escalonador_instrucoes #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned PARTITION_SIZE = 200,
   parameter int unsigned NUM_PROGS      = 2,
   parameter int unsigned QUANTUM        = 64
) (
   input  logic                     clock,
   input  logic                     reset_n,
   escalonador_instrucoes_if.slave  bus
);
   import escalonador_pkg::*;

   localparam int unsigned CW = $clog2(QUANTUM + 1);
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   estado_t              estado_q, estado_d;
   logic [2:0]           proc_q, proc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_PROGS-1:0] ativos_q, ativos_d;
   logic                 troca_q, troca_d;
   logic [2:0]           rr_proximo;
   logic                 rr_nenhum;
   logic                 fora_limite;
   logic [MAX_PROGS-1:0] um_quente;
   addr_t                base_tab [MAX_PROGS];
   addr_t                base_atual;

   for (genvar g = 0; g < MAX_PROGS; g++) begin : g_base
      assign base_tab[g] = addr_t'(base_prog(32'(g), PARTITION_SIZE));
   end

   seletor_round_robin #(.NUM_PROGS(NUM_PROGS)) u_rr (
      .ativos  (ativos_q),
      .atual   (proc_q),
      .pedido  (bus.proximo_proc),
      .proximo (rr_proximo),
      .nenhum  (rr_nenhum)
   );

`ifdef SCHED_LIMIT_CHECK_EN
   logic falha_q;

   assign fora_limite = (estado_q == USER) && (bus.pc_logico >= addr_t'(PARTITION_SIZE));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) falha_q <= 1'b0;
      else          falha_q <= falha_q | fora_limite;
   end

   assign bus.falha_limite = falha_q;
`else
   assign fora_limite = 1'b0;
`endif

   assign um_quente = MAX_PROGS'(1) << proc_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= SO;
         proc_q   <= '0;
         cnt_q    <= '0;
         ativos_q <= '1;
         troca_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         proc_q   <= proc_d;
         cnt_q    <= cnt_d;
         ativos_q <= ativos_d;
         troca_q  <= troca_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      proc_d   = proc_q;
      cnt_d    = cnt_q;
      ativos_d = ativos_q;
      troca_d  = 1'b0;
      case (estado_q)
         USER: begin
            // Halt/fault takes priority so a coincident quantum expiry still clears the bit.
            if (bus.prog_fim || fora_limite) begin
               ativos_d = ativos_q & ~um_quente[NUM_PROGS-1:0];
               cnt_d    = '0;
               troca_d  = 1'b1;
               estado_d = ROTINA;
            end else if (bus.instr_ret) begin
               if (cnt_q == CW'(QUANTUM - 1)) begin
                  cnt_d    = '0;
                  troca_d  = 1'b1;
                  estado_d = ROTINA;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ROTINA: begin
            cnt_d = '0;
            if (bus.rotina_fim) begin
               troca_d  = 1'b1;
               estado_d = rr_nenhum ? FIM : SO;
            end
         end
         SO: begin
            if (bus.so_fim) begin
               troca_d = 1'b1;
               if (rr_nenhum) begin
                  estado_d = FIM;
               end else begin
                  proc_d   = rr_proximo;
                  estado_d = USER;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      base_atual = addr_t'(PARTITION_SIZE);
      case (estado_q)
         ROTINA:  base_atual = addr_t'(BASE_ROTINA);
         USER:    base_atual = base_tab[proc_q];
         default: ;
      endcase
   end

   assign bus.endereco    = fora_limite ? base_atual : base_atual + bus.pc_logico;
   assign bus.troca_req   = troca_q;
   assign bus.modo_kernel = (estado_q != USER);
   assign bus.proc_atual  = proc_q;
   assign bus.ativos      = ativos_q;
   assign bus.concluido   = (estado_q == FIM);

endmodule

// File: tb/tb_escalonador_instrucoes.sv
// Bench for escalonador_instrucoes: fixed vector table, corner sequences and
// randomized traffic against a behavioural scheduler model.
module tb_escalonador_instrucoes;

   localparam int unsigned AW = 32;
   localparam int unsigned PS = 200;
   localparam int unsigned NP = 2;
   localparam int unsigned QT = 64;
`ifdef SCHED_LIMIT_CHECK_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   localparam int M_USER = 0, M_ROT = 1, M_SO = 2, M_FIM = 3;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   escalonador_instrucoes_if #(.ADDR_WIDTH(AW), .NUM_PROGS(NP)) bus ();

   escalonador_instrucoes #(
      .ADDR_WIDTH(AW), .PARTITION_SIZE(PS), .NUM_PROGS(NP), .QUANTUM(QT)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic ck(input string nome, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", nome, got, exp, $time);
      end
   endtask

   // Behavioural model: which program runs, retirements in this slice, live set.
   int              m_mode, m_prog, m_ret;
   bit              m_alive [NP];
   bit              m_troca, m_falha;
   longint unsigned m_pc;

   function automatic int alive_count();
      int n = 0;
      for (int k = 0; k < NP; k++) n += m_alive[k];
      return n;
   endfunction

   function automatic longint unsigned alive_mask();
      longint unsigned m = 0;
      for (int k = 0; k < NP; k++) if (m_alive[k]) m += (64'd1 << k);
      return m;
   endfunction

   function automatic longint unsigned exp_addr();
      longint unsigned a;
      case (m_mode)
         M_USER:  a = (LIMIT && m_pc >= PS) ? (m_prog + 2) * PS : (m_prog + 2) * PS + m_pc;
         M_ROT:   a = m_pc;
         default: a = PS + m_pc;
      endcase
      return a & 64'hFFFF_FFFF;
   endfunction

   task automatic model_reset();
      m_mode = M_SO; m_prog = 0; m_ret = 0; m_troca = 0; m_falha = 0;
      for (int k = 0; k < NP; k++) m_alive[k] = 1'b1;
   endtask

   task automatic model_step(input longint unsigned pc, input bit ir, pf, rf, sf, input int px);
      bit fault;
      m_troca = 0;
      case (m_mode)
         M_USER: begin
            fault = LIMIT && (pc >= PS);
            if (fault) m_falha = 1;
            if (pf || fault) begin
               m_alive[m_prog] = 0; m_ret = 0; m_troca = 1; m_mode = M_ROT;
            end else if (ir) begin
               m_ret++;
               if (m_ret == QT) begin
                  m_ret = 0; m_troca = 1; m_mode = M_ROT;
               end
            end
         end
         M_ROT: if (rf) begin
            m_troca = 1;
            m_mode  = (alive_count() > 0) ? M_SO : M_FIM;
         end
         M_SO: if (sf) begin
            m_troca = 1;
            if (alive_count() == 0) m_mode = M_FIM;
            else begin
               if (px < NP && m_alive[px]) m_prog = px;
               else begin
                  for (int k = 1; k <= NP; k++) begin
                     if (m_alive[(m_prog + k) % NP]) begin
                        m_prog = (m_prog + k) % NP;
                        break;
                     end
                  end
               end
               m_mode = M_USER;
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_model();
      ck("endereco",    bus.endereco,    exp_addr());
      ck("troca_req",   bus.troca_req,   m_troca);
      ck("modo_kernel", bus.modo_kernel, (m_mode != M_USER));
      ck("proc_atual",  bus.proc_atual,  m_prog);
      ck("ativos",      bus.ativos,      alive_mask());
      ck("concluido",   bus.concluido,   (m_mode == M_FIM));
`ifdef SCHED_LIMIT_CHECK_EN
      ck("falha_limite", bus.falha_limite, m_falha);
`endif
   endtask

   task automatic tick(input longint unsigned pc, input bit ir, pf, rf, sf, input int px);
      bus.pc_logico    = AW'(pc);
      bus.instr_ret    = ir;
      bus.prog_fim     = pf;
      bus.rotina_fim   = rf;
      bus.so_fim       = sf;
      bus.proximo_proc = 3'(px);
      @(posedge clock);
      model_step(pc, ir, pf, rf, sf, px);
      m_pc = pc;
      #1;
      bus.instr_ret  = 1'b0;
      bus.prog_fim   = 1'b0;
      bus.rotina_fim = 1'b0;
      bus.so_fim     = 1'b0;
      check_model();
   endtask

   // Reset is asserted mid-cycle and checked before any clock edge.
   task automatic do_reset(input longint unsigned pc);
      @(negedge clock);
      bus.pc_logico = AW'(pc);
      m_pc    = pc;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_model();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   typedef struct {
      longint unsigned pc;
      bit ir, pf, rf, sf;
      int px;
      longint unsigned e_end;
      bit e_troca, chk_troca, e_kern;
      int e_proc, e_ativ;
      bit e_conc;
   } vec_t;

   function automatic vec_t mk(longint unsigned pc, bit ir, bit pf, bit rf, bit sf, int px,
                               longint unsigned e_end, bit e_troca, bit chk_troca, bit e_kern,
                               int e_proc, int e_ativ, bit e_conc);
      vec_t v;
      v.pc = pc; v.ir = ir; v.pf = pf; v.rf = rf; v.sf = sf; v.px = px;
      v.e_end = e_end; v.e_troca = e_troca; v.chk_troca = chk_troca; v.e_kern = e_kern;
      v.e_proc = e_proc; v.e_ativ = e_ativ; v.e_conc = e_conc;
      return v;
   endfunction

   vec_t tab [10];

   initial begin
      bus.pc_logico = '0; bus.instr_ret = 0; bus.prog_fim = 0;
      bus.rotina_fim = 0; bus.so_fim = 0; bus.proximo_proc = '0;
      model_reset();

      //            pc ir pf rf sf px   end  trc chk krn prc atv cnc
      tab[0] = mk(5,  0, 0, 0, 1, 1,  605, 1, 1, 0, 1, 3, 0);
      tab[1] = mk(5,  0, 0, 0, 0, 0,  605, 0, 1, 0, 1, 3, 0);
      tab[2] = mk(5,  1, 0, 0, 0, 0,  605, 0, 1, 0, 1, 3, 0);
      tab[3] = mk(7,  0, 1, 0, 0, 0,    7, 1, 1, 1, 1, 1, 0);
      tab[4] = mk(9,  0, 0, 1, 0, 0,  209, 1, 1, 1, 1, 1, 0);
      tab[5] = mk(3,  0, 0, 0, 1, 1,  403, 1, 1, 0, 0, 1, 0);
      tab[6] = mk(3,  0, 1, 0, 0, 0,    3, 1, 1, 1, 0, 0, 0);
      tab[7] = mk(4,  0, 0, 1, 0, 0,  204, 0, 0, 1, 0, 0, 1);
      tab[8] = mk(4,  1, 0, 0, 1, 0,  204, 0, 1, 1, 0, 0, 1);
      tab[9] = mk(4,  0, 1, 1, 0, 0,  204, 0, 1, 1, 0, 0, 1);

      do_reset(5);
      ck("rst_end",   bus.endereco,    205);
      ck("rst_kern",  bus.modo_kernel, 1);
      ck("rst_troca", bus.troca_req,   0);
      ck("rst_proc",  bus.proc_atual,  0);
      ck("rst_ativ",  bus.ativos,      3);
      ck("rst_conc",  bus.concluido,   0);

      for (int i = 0; i < 10; i++) begin
         tick(tab[i].pc, tab[i].ir, tab[i].pf, tab[i].rf, tab[i].sf, tab[i].px);
         ck($sformatf("vec%0d_end", i),  bus.endereco,    tab[i].e_end);
         if (tab[i].chk_troca) ck($sformatf("vec%0d_troca", i), bus.troca_req, tab[i].e_troca);
         ck($sformatf("vec%0d_kern", i), bus.modo_kernel, tab[i].e_kern);
         ck($sformatf("vec%0d_proc", i), bus.proc_atual,  tab[i].e_proc);
         ck($sformatf("vec%0d_ativ", i), bus.ativos,      tab[i].e_ativ);
         ck($sformatf("vec%0d_conc", i), bus.concluido,   tab[i].e_conc);
      end

      // Quantum: 63 retirements keep the program, the 64th forces a switch.
      do_reset(10);
      tick(10, 0, 0, 0, 1, 0);
      ck("q_entra_end", bus.endereco, 410);
      for (int i = 0; i < 63; i++) tick(10, 1, 0, 0, 0, 0);
      ck("q63_kern", bus.modo_kernel, 0);
      tick(10, 1, 0, 0, 0, 0);
      ck("q64_troca", bus.troca_req,   1);
      ck("q64_kern",  bus.modo_kernel, 1);
      ck("q64_end",   bus.endereco,    10);

      // Halt coinciding with quantum expiry, then reset inside the routine.
      do_reset(10);
      tick(10, 0, 0, 0, 1, 0);
      for (int i = 0; i < 63; i++) tick(10, 1, 0, 0, 0, 0);
      tick(10, 1, 1, 0, 0, 0);
      ck("simult_troca", bus.troca_req, 1);
      ck("simult_ativ",  bus.ativos,    2);
      tick(10, 1, 0, 0, 0, 0);
      ck("simult_pulso_unico", bus.troca_req, 0);
      ck("rot_end",            bus.endereco,  10);
      do_reset(20);
      ck("rst_rot_kern", bus.modo_kernel, 1);
      ck("rst_rot_end",  bus.endereco,    220);
      ck("rst_rot_ativ", bus.ativos,      3);

      // Finished request falls back round-robin to the other program.
      do_reset(0);
      tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 1, 0, 0, 0);
      ck("rr_ativ", bus.ativos, 2);
      tick(0, 0, 0, 1, 0, 0);
      ck("rr_so_end", bus.endereco, 200);
      tick(30, 0, 0, 0, 1, 0);
      ck("rr_proc", bus.proc_atual, 1);
      ck("rr_end",  bus.endereco,   630);

`ifdef SCHED_LIMIT_CHECK_EN
      do_reset(0);
      tick(5, 0, 0, 0, 1, 1);
      bus.pc_logico = AW'(200);
      #1;
      ck("lim_end", bus.endereco, 600);
      tick(200, 0, 0, 0, 0, 0);
      ck("lim_falha", bus.falha_limite, 1);
      ck("lim_ativ",  bus.ativos,       1);
      ck("lim_troca", bus.troca_req,    1);
      tick(0, 0, 0, 0, 0, 0);
      ck("lim_sticky", bus.falha_limite, 1);
`endif

      // Randomized traffic against the model, with occasional resets.
      do_reset(0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset(longint'($urandom_range(0, 260)));
         end else begin
            tick(longint'($urandom_range(0, 260)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 7)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
